cordic_exp_iter: RTL and testbench
==================================

// Module: cordic_exp_iter
// PURPOSE
//  Iteration controller/datapath directly downstream of the CORDIC k/e^k lookup stage.
//  - Accepts an operand x and drives the lookup stage with the residual x and a start address.
//  - Consumes each returned (k, e^k, addr) entry: x_res -= k, y *= e^k (fixed point).
//  - Result: y ~= e^x_in plus the final residual.
// PARAMETERS
//  W       32  datapath/LUT entry width (unsigned fixed point)
//  FRAC    16  fractional bits; ONE = 1<<FRAC
//  DEPTH   32  LUT entries; LAST = DEPTH-1
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      operand offered
//  in_ready     out  1      high only in IDLE
//  in_x         in   W      operand x (unsigned, Qx.FRAC)
//  lut_req      out  1      one-cycle pulse: lookup request
//  lut_x        out  W+1    residual x presented to lookup stage (MSB zero)
//  lut_addr     out  5      start address for lookup scan
//  lut_valid    in   1      lookup result valid (one cycle)
//  lut_k        in   W      returned k
//  lut_e_k      in   W      returned e^k
//  lut_addr_ret in   5      address the lookup stopped at
//  out_valid    out  1      result valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  out_y        out  W      product y
//  out_res      out  W      final residual x
//  out_ovf      out  1      overflow seen (macro-dependent)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, lut_req=0, lut_x=0, lut_addr=0, out_valid=0, out_y=0, out_res=0, out_ovf=0.
//  FSM: IDLE -> REQ -> WAIT -> UPD -> (REQ | DONE); DONE -> IDLE.
//  IDLE: on in_valid, load x_res=in_x, y=ONE, addr=0, ovf=0.
//    If in_x==0: go directly to DONE; no lookup is issued.
//  REQ: lut_req=1 for exactly one cycle; lut_x={1'b0,x_res}, lut_addr=addr. Go to WAIT.
//  WAIT: hold until lut_valid. There is no timeout. lut_valid in any other state is ignored.
//  UPD (1 cycle), with a = lut_addr_ret:
//    - If lut_k <= x_res: x_res -= lut_k; y = (y*lut_e_k)>>FRAC using a full 2W product, truncating LSBs.
//    - Else (LAST entry returned unconditionally with k > x_res): no update.
//    - Next: DONE if a==LAST, x_res becomes 0, or a+1 > LAST; else addr=a+1 and go to REQ.
//    - Each entry is applied at most once. No 5-bit wrap: a==31 always terminates.
//  DONE: out_valid=1; out_y/out_res/out_ovf stable until out_ready. Handshake completes on the cycle both are high.
//    out_valid falls the next cycle; state returns to IDLE.
//  Latency per iteration: 3 cycles plus lookup-stage latency. Worst case is DEPTH iterations.
//  rst mid-operation: abandons the iteration immediately and restores reset values.
//    A late lut_valid arriving after reset is ignored (state is IDLE).
//  in_valid is ignored while busy (in_ready=0).
// CONFIGURATION
//  CORDIC_EXP_SAT_EN defined:
//    - If product bits above W+FRAC are nonzero, y saturates to all-ones and the sticky ovf bit is set.
//    - Later iterations keep y saturated.
//  Not defined: y takes product[W+FRAC-1:FRAC] (wraps); out_ovf is tied 0.
// STRUCTURE
//  cordic_pkg: W, FRAC, DEPTH, LAST, ONE, state encoding (S_IDLE, S_REQ, S_WAIT, S_UPD, S_DONE).
//  The lookup stage also imports cordic_pkg.
//  Sub-module cordic_fx_mul: combinational WxW -> 2W multiply with shift by FRAC.
//    Same ports in both builds; its saturate/ovf output is active only under CORDIC_EXP_SAT_EN.
// TESTING (FRAC=16, stub LUT: entry0 k=0xB172 (ln2) e_k=0x20000; entries 1..31 k=0xFFFFFFFF e_k=ONE)
//  1) in_x=0 -> no lut_req ever; out_y=0x10000, out_res=0, out_valid 2 cycles after accept.
//  2) in_x=0xB172 -> one lut_req (addr=0); out_y=0x20000, out_res=0.
//  3) in_x=0xC000:
//     - request 1 returns addr 0 -> out_res=0xE8E after the update.
//     - request 2 has lut_addr=1; stub returns addr 31 with k > res -> no update.
//     - out_y=0x20000.
//  4) Stub entry0 e_k=0xFFFFFFFF, y preset via repeated entries:
//     - with CORDIC_EXP_SAT_EN: out_y=0xFFFFFFFF, out_ovf=1.
//     - without it: wrapped value, out_ovf=0.
//  5) Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE next cycle.
//  6) Assert rst while in WAIT, then pulse lut_valid -> all outputs at reset values; next operand runs cleanly.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cordic_pkg                                                            |
// | Shared widths, constants and FSM encoding for the CORDIC e^x blocks.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cordic_pkg;

  localparam int W     = 32;
  localparam int FRAC  = 16;
  localparam int DEPTH = 32;
  localparam int LAST  = DEPTH - 1;
  localparam int AW    = 5;

  localparam logic [AW-1:0] LAST_ADDR = AW'(LAST);
  localparam logic [W-1:0]  ONE       = W'(1) << FRAC;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_fx_mul.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cordic_fx_mul                                                         |
// | Combinational WxW fixed-point multiply, result = (a*b) >> FRAC.       |
// | o_ovf flags product bits above W+FRAC (only with CORDIC_EXP_SAT_EN).  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cordic_fx_mul
  import cordic_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y,
  output logic         o_ovf
);

  logic [2*W-1:0] w_prod;
  logic           w_unused;

  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign o_y    = w_prod[W+FRAC-1:FRAC];

`ifdef CORDIC_EXP_SAT_EN
  assign o_ovf    = |w_prod[2*W-1:W+FRAC];
  assign w_unused = ^w_prod[FRAC-1:0];
`else
  assign o_ovf    = 1'b0;
  assign w_unused = ^{w_prod[2*W-1:W+FRAC], w_prod[FRAC-1:0]};
`endif

endmodule
`default_nettype wire

// File: rtl/cordic_exp_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cordic_exp_iter                                                       |
// | Iterative e^x controller driving the k/e^k lookup stage.              |
// | Optional saturation: define CORDIC_EXP_SAT_EN.                        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cordic_exp_iter
  import cordic_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  i_in_x,
  output logic          o_lut_req,
  output logic [W:0]    o_lut_x,
  output logic [AW-1:0] o_lut_addr,
  input  logic          i_lut_valid,
  input  logic [W-1:0]  i_lut_k,
  input  logic [W-1:0]  i_lut_e_k,
  input  logic [AW-1:0] i_lut_addr_ret,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [W-1:0]  o_out_y,
  output logic [W-1:0]  o_out_res,
  output logic          o_out_ovf
);

  state_t        r_state;
  state_t        w_next;

  logic [W-1:0]  r_x_res;
  logic [W-1:0]  r_y;
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_k;
  logic [W-1:0]  r_ek;
  logic [AW-1:0] r_a;

  logic          w_apply;
  logic [W-1:0]  w_x_new;
  logic          w_stop;
  logic [W-1:0]  w_mul_y;
  logic          w_mul_ovf;
  logic [W-1:0]  w_y_new;

  cordic_fx_mul u_mul (
    .i_a   (r_y),
    .i_b   (r_ek),
    .o_y   (w_mul_y),
    .o_ovf (w_mul_ovf)
  );

  // The last entry comes back even when its k exceeds the residual; skip it then.
  assign w_apply = (r_k <= r_x_res);
  assign w_x_new = w_apply ? (r_x_res - r_k) : r_x_res;
  assign w_stop  = (r_a == LAST_ADDR) || (w_x_new == '0) ||
                   (({1'b0, r_a} + 6'd1) > {1'b0, LAST_ADDR});

`ifdef CORDIC_EXP_SAT_EN
  logic r_ovf;
  assign w_y_new   = (w_mul_ovf || r_ovf) ? {W{1'b1}} : w_mul_y;
  assign o_out_ovf = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && i_in_valid) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_UPD && w_apply) begin
      r_ovf <= r_ovf | w_mul_ovf;
    end
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_mul_ovf;
  assign w_y_new      = w_mul_y;
  assign o_out_ovf    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid) w_next = (i_in_x == '0) ? S_DONE : S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (i_lut_valid) w_next = S_UPD;
      S_UPD:   w_next = w_stop ? S_DONE : S_REQ;
      S_DONE:  if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_res <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_k     <= '0;
      r_ek    <= '0;
      r_a     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_x_res <= i_in_x;
            r_y     <= ONE;
            r_addr  <= '0;
          end
        end
        S_WAIT: begin
          if (i_lut_valid) begin
            r_k  <= i_lut_k;
            r_ek <= i_lut_e_k;
            r_a  <= i_lut_addr_ret;
          end
        end
        S_UPD: begin
          if (w_apply) begin
            r_x_res <= w_x_new;
            r_y     <= w_y_new;
          end
          if (!w_stop) r_addr <= r_a + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_lut_req   = (r_state == S_REQ);
  assign o_lut_x     = {1'b0, r_x_res};
  assign o_lut_addr  = r_addr;
  assign o_out_valid = (r_state == S_DONE);
  assign o_out_y     = r_y;
  assign o_out_res   = r_x_res;

endmodule
`default_nettype wire

// File: tb/tb_cordic_exp_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cordic_exp_iter                                                    |
// | Directed bench with a behavioural k/e^k lookup stub.                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_cordic_exp_iter;
  import cordic_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_in_x;
  logic          o_lut_req;
  logic [W:0]    o_lut_x;
  logic [AW-1:0] o_lut_addr;
  logic          i_lut_valid;
  logic [W-1:0]  i_lut_k;
  logic [W-1:0]  i_lut_e_k;
  logic [AW-1:0] i_lut_addr_ret;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [W-1:0]  o_out_y;
  logic [W-1:0]  o_out_res;
  logic          o_out_ovf;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  lk  [DEPTH];
  logic [W-1:0]  lek [DEPTH];
  int            lat     = 1;
  int            req_cnt = 0;
  logic [AW-1:0] req_addr_q [$];

  always #5 clk = ~clk;

  cordic_exp_iter dut (
    .clk            (clk),
    .rst            (rst),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_in_x         (i_in_x),
    .o_lut_req      (o_lut_req),
    .o_lut_x        (o_lut_x),
    .o_lut_addr     (o_lut_addr),
    .i_lut_valid    (i_lut_valid),
    .i_lut_k        (i_lut_k),
    .i_lut_e_k      (i_lut_e_k),
    .i_lut_addr_ret (i_lut_addr_ret),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_y        (o_out_y),
    .o_out_res      (o_out_res),
    .o_out_ovf      (o_out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lut_default();
    for (int i = 0; i < DEPTH; i++) begin
      lk[i]  = 32'hFFFF_FFFF;
      lek[i] = ONE;
    end
    lk[0]  = 32'h0000_B172;
    lek[0] = 32'h0002_0000;
  endtask

  // Lookup stub: scans upward from the start address for the first k <= x, else LAST.
  initial begin
    int a;
    i_lut_valid    = 1'b0;
    i_lut_k        = '0;
    i_lut_e_k      = '0;
    i_lut_addr_ret = '0;
    forever begin
      @(posedge clk); #1;
      if (o_lut_req) begin
        req_cnt++;
        req_addr_q.push_back(o_lut_addr);
        a = int'(o_lut_addr);
        while (a < LAST && lk[a] > o_lut_x[W-1:0]) a++;
        repeat (lat) @(posedge clk);
        #1;
        i_lut_valid    = 1'b1;
        i_lut_k        = lk[a];
        i_lut_e_k      = lek[a];
        i_lut_addr_ret = AW'(a);
        @(posedge clk); #1;
        i_lut_valid = 1'b0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  o_in_ready, 1);
    chk({tag, "_lut_req"},   o_lut_req, 0);
    chk({tag, "_lut_x"},     o_lut_x, 0);
    chk({tag, "_lut_addr"},  o_lut_addr, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_out_y"},     o_out_y, 0);
    chk({tag, "_out_res"},   o_out_res, 0);
    chk({tag, "_out_ovf"},   o_out_ovf, 0);
  endtask

  task automatic start_op(input string tag, input logic [W-1:0] x);
    req_cnt = 0;
    req_addr_q.delete();
    @(negedge clk);
    chk({tag, "_ready"}, o_in_ready, 1);
    i_in_valid = 1'b1;
    i_in_x     = x;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, output int n);
    start_op(tag, x);
    n = 1;
    while (!o_out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, o_out_valid, 1);
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    chk({tag, "_vld_drop"}, o_out_valid, 0);
    chk({tag, "_idle"},     o_in_ready, 1);
  endtask

  initial begin
    int n;
    logic [W-1:0] y_hold, r_hold;
    logic [W-1:0] exp_y4;
    logic         exp_ovf4;

    rst         = 1'b1;
    i_in_valid  = 1'b0;
    i_in_x      = '0;
    i_out_ready = 1'b0;
    lut_default();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // 1) zero operand: no lookup at all
    run_op("t1", 32'h0, n);
    chk("t1_latency_le2", (n <= 2), 1);
    chk("t1_nreq", req_cnt, 0);
    chk("t1_y",    o_out_y, 32'h0001_0000);
    chk("t1_res",  o_out_res, 0);
    finish_op("t1");

    // 2) x = ln2: one entry applied, residual hits zero
    run_op("t2", 32'h0000_B172, n);
    chk("t2_nreq",  req_cnt, 1);
    chk("t2_addr0", req_addr_q[0], 0);
    chk("t2_y",     o_out_y, 32'h0002_0000);
    chk("t2_res",   o_out_res, 0);
    finish_op("t2");

    // 3) x = 0.75: entry 0 applied, then LAST returned with k > residual
    run_op("t3", 32'h0000_C000, n);
    chk("t3_nreq",  req_cnt, 2);
    chk("t3_addr0", req_addr_q[0], 0);
    chk("t3_addr1", req_addr_q[1], 1);
    chk("t3_y",     o_out_y, 32'h0002_0000);
    chk("t3_res",   o_out_res, 32'h0000_0E8E);

    // 5) back-pressure in DONE; a new in_valid must be ignored meanwhile
    y_hold = o_out_y;
    r_hold = o_out_res;
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_x     = 32'h0000_1234;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_hold%0d", i), {o_out_valid, o_in_ready, o_out_y, o_out_res},
          {1'b1, 1'b0, y_hold, r_hold});
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    finish_op("t5");

    // 4) overflow: y -> 0xFFFFFFFF, then x2 overflows, then x0.5
    lk[0] = 32'h1; lek[0] = 32'hFFFF_FFFF;
    lk[1] = 32'h1; lek[1] = 32'h0002_0000;
    lk[2] = 32'h1; lek[2] = 32'h0000_8000;
`ifdef CORDIC_EXP_SAT_EN
    exp_y4   = 32'hFFFF_FFFF;
    exp_ovf4 = 1'b1;
`else
    exp_y4   = 32'h7FFF_FFFF;
    exp_ovf4 = 1'b0;
`endif
    run_op("t4", 32'h0000_0010, n);
    chk("t4_nreq",  req_cnt, 4);
    chk("t4_addr3", req_addr_q[3], 3);
    chk("t4_y",     o_out_y, exp_y4);
    chk("t4_ovf",   o_out_ovf, exp_ovf4);
    chk("t4_res",   o_out_res, 32'h0000_000D);
    finish_op("t4");
    lut_default();

    // 6) reset while waiting on a slow lookup; its late response lands in IDLE
    lat = 6;
    start_op("t6", 32'h0000_C000);
    n = 0;
    while (req_cnt == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_req_seen", req_cnt, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_reset_vals("t6_after");
    lat = 1;
    run_op("t6b", 32'h0000_B172, n);
    chk("t6b_y",   o_out_y, 32'h0002_0000);
    chk("t6b_res", o_out_res, 0);
    finish_op("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
